// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: picks, starts, times and counts obstacle generators and muxes the active slot's data
module obstacle_sequencer #(
    parameter int          NUM_OBS        = 8,
    parameter int          SEL_W          = 4,
    parameter int          DATA_W         = 36,
    parameter int          MODE           = 1,
    parameter int          GAP_CYCLES     = 1024,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter int          WIN_COUNT      = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_OBS-1:0]        done_in,
    input  logic [NUM_OBS*DATA_W-1:0] obs_data_in,
    output logic [SEL_W-1:0]          obs_select,
    output logic                      obs_start,
    output logic                      obs_active,
    output logic [DATA_W-1:0]         obs_data_out,
    output logic [15:0]               obstacles_counted,
    output logic                      victory,
    output logic                      timeout
);
    localparam int NS = 1 << SEL_W;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, WIN} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [NS-1:0]     mask_q, mask_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  cand_q, cand_d;
    logic              fresh_q, fresh_d;
    logic              first_q, first_d;
    logic              epoch_q, epoch_d;
    logic              start_q, start_d;
    logic              to_q, to_d;
    logic [31:0]       run_q, run_d;
    logic [31:0]       gap_q, gap_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [DATA_W-1:0] slot [NS];
    logic [NS-1:0]     done_ext;
    logic [NS-1:0]     mask_eff, sel_bit, pick_bit;
    logic [SEL_W-1:0]  try_sel, step, pick;
    logic [15:0]       cnt_inc;
    logic              full, epoch, pick_ok, done_hit, to_hit;

    // Pad slots up to the full select range so out-of-range codes read as zero / never done
    for (genvar i = 0; i < NS; i++) begin : g_slot
        if (i < NUM_OBS) begin : g_on
            assign slot[i]     = obs_data_in[i*DATA_W +: DATA_W];
            assign done_ext[i] = done_in[i];
        end else begin : g_off
            assign slot[i]     = '0;
            assign done_ext[i] = 1'b0;
        end
    end

    // Candidate for this LOAD cycle and the run-completion conditions
    always_comb begin
        full     = &mask_q[NUM_OBS-1:0];
        epoch    = epoch_q || full;
        sel_bit  = NS'(1) << sel_q;
        mask_eff = full ? sel_bit : mask_q;
        try_sel  = first_q ? lfsr_q[SEL_W-1:0] : cand_q;
        step     = (32'(try_sel) >= NUM_OBS - 1) ? '0 : try_sel + 1'b1;
        pick     = (MODE == 0) ? ((fresh_q || 32'(sel_q) >= NUM_OBS - 1) ? '0 : sel_q + 1'b1) : try_sel;
        pick_ok  = (MODE == 0) || (32'(try_sel) < NUM_OBS && !mask_eff[try_sel]);
        pick_bit = NS'(1) << pick;
        done_hit = done_ext[sel_q] && run_q != 32'd0;
        to_hit   = TIMEOUT_CYCLES != 0 && run_q == 32'(TIMEOUT_CYCLES - 1);
        cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state: abort beats start beats the sequencing states
    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        mask_d  = mask_q;
        sel_d   = sel_q;
        cand_d  = cand_q;
        fresh_d = fresh_q;
        first_d = 1'b0;
        epoch_d = epoch_q;
        start_d = 1'b0;
        to_d    = 1'b0;
        run_d   = run_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        data_d  = (state_q == RUN) ? slot[sel_q] : '0;
        if (abort) begin
            state_d = IDLE;
            mask_d  = '0;
            epoch_d = 1'b0;
        end else if (start && (state_q == IDLE || state_q == WIN)) begin
            state_d = LOAD;
            cnt_d   = '0;
            mask_d  = '0;
            epoch_d = 1'b0;
            fresh_d = 1'b1;
            first_d = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (pick_ok) begin
                        state_d = RUN;
                        sel_d   = pick;
                        mask_d  = epoch ? pick_bit : (mask_eff | pick_bit);
                        epoch_d = 1'b0;
                        fresh_d = 1'b0;
                        start_d = 1'b1;
                        run_d   = '0;
                    end else begin
                        mask_d  = mask_eff;
                        epoch_d = epoch;
                        cand_d  = step;
                    end
                end
                RUN: begin
                    run_d = run_q + 1'b1;
                    if (done_hit || to_hit) begin
                        cnt_d   = cnt_inc;
                        to_d    = to_hit && !done_hit;
                        gap_d   = '0;
                        state_d = (WIN_COUNT != 0 && cnt_inc == 16'(WIN_COUNT)) ? WIN :
                                  (GAP_CYCLES == 0) ? LOAD : GAP;
                        first_d = (state_d == LOAD);
                    end
                end
                GAP: begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == 32'(GAP_CYCLES - 1)) begin
                        state_d = LOAD;
                        first_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            mask_q  <= '0;
            sel_q   <= '0;
            cand_q  <= '0;
            fresh_q <= 1'b0;
            first_q <= 1'b0;
            epoch_q <= 1'b0;
            start_q <= 1'b0;
            to_q    <= 1'b0;
            run_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cand_q  <= cand_d;
            fresh_q <= fresh_d;
            first_q <= first_d;
            epoch_q <= epoch_d;
            start_q <= start_d;
            to_q    <= to_d;
            run_q   <= run_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign obs_select        = sel_q;
    assign obs_start         = start_q;
    assign obs_active        = state_q == RUN;
    assign obs_data_out      = data_q;
    assign obstacles_counted = cnt_q;
    assign victory           = state_q == WIN;
    assign timeout           = to_q;
endmodule

// File: tb/tb_obstacle_sequencer.sv
// tb_obstacle_sequencer: directed checks of sequential, random and timeout configurations
module tb_obstacle_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [3:0] done0 = '0, done2 = '0;
    logic [4:0] done1 = '0;
    logic [143:0] data4 = '0;
    logic [179:0] data5 = '0;
    logic [1:0] sel0, sel2;
    logic [2:0] sel1;
    logic st0, st1, st2, act0, act1, act2, vic0, vic1, vic2, to0, to1, to2;
    logic [35:0] dout0, dout1, dout2;
    logic [15:0] cnt0, cnt1, cnt2;
    int checks = 0, errors = 0, starts0 = 0;
    logic [35:0] slot_v [4] = '{36'hA00_000_001, 36'hB11_111_112, 36'hC22_222_223, 36'h123_456_F00};
    int exp_sel [6] = '{0, 1, 2, 3, 0, 1};
    int picks [10];

    obstacle_sequencer #(.NUM_OBS(4), .SEL_W(2), .DATA_W(36), .MODE(0), .GAP_CYCLES(2),
                         .TIMEOUT_CYCLES(0), .WIN_COUNT(6)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .done_in(done0), .obs_data_in(data4),
        .obs_select(sel0), .obs_start(st0), .obs_active(act0), .obs_data_out(dout0),
        .obstacles_counted(cnt0), .victory(vic0), .timeout(to0));

    obstacle_sequencer #(.NUM_OBS(5), .SEL_W(3), .DATA_W(36), .MODE(1), .GAP_CYCLES(3),
                         .TIMEOUT_CYCLES(0), .WIN_COUNT(10)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .done_in(done1), .obs_data_in(data5),
        .obs_select(sel1), .obs_start(st1), .obs_active(act1), .obs_data_out(dout1),
        .obstacles_counted(cnt1), .victory(vic1), .timeout(to1));

    obstacle_sequencer #(.NUM_OBS(4), .SEL_W(2), .DATA_W(36), .MODE(0), .GAP_CYCLES(2),
                         .TIMEOUT_CYCLES(100), .WIN_COUNT(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .done_in(done2), .obs_data_in(data4),
        .obs_select(sel2), .obs_start(st2), .obs_active(act2), .obs_data_out(dout2),
        .obstacles_counted(cnt2), .victory(vic2), .timeout(to2));

    always #5 clk = ~clk;

    always @(negedge clk) if (st0) starts0++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int u);
        int n = 0;
        while (!(u == 0 ? st0 : u == 1 ? st1 : st2) && n < 60) begin
            tick();
            n++;
        end
        check($sformatf("wait_start%0d", u), n < 60, 1);
    endtask

    initial begin
        logic [7:0] seen_a, seen_b;
        int n;
        data4 = {slot_v[3], slot_v[2], slot_v[1], slot_v[0]};
        tick();
        tick();
        check("rst_sel", sel0, 0);
        check("rst_start", st0, 0);
        check("rst_active", act0, 0);
        check("rst_data", dout0, 0);
        check("rst_count", cnt0, 0);
        check("rst_victory", vic0, 0);
        check("rst_timeout", to0, 0);
        rst = 1'b1;
        tick();

        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_start(0);
            check("u0_sel", sel0, exp_sel[k]);
            check("u0_act", act0, 1);
            tick();
            check("u0_pulse", st0, 0);
            check("u0_data", dout0, slot_v[exp_sel[k]]);
            done0 = 4'(1 << ((exp_sel[k] + 1) % 4));
            tick();
            done0 = '0;
            check("u0_other_done", act0, 1);
            tick();
            tick();
            done0 = 4'(1 << exp_sel[k]);
            tick();
            done0 = '0;
            check("u0_count", cnt0, k + 1);
            check("u0_active_off", act0, 0);
            check("u0_victory", vic0, k == 5);
            tick();
            check("u0_data_zero", dout0, 0);
        end
        check("u0_starts", starts0, 6);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("u0_abort_victory", vic0, 0);
        check("u0_abort_count", cnt0, 6);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int p = 0; p < 10; p++) begin
            wait_start(1);
            picks[p] = int'(sel1);
            tick();
            done1 = 5'(1 << sel1);
            tick();
            done1 = '0;
        end
        check("u1_victory", vic1, 1);
        check("u1_count", cnt1, 10);
        seen_a = '0;
        seen_b = '0;
        for (int p = 0; p < 5; p++) begin
            seen_a |= 8'(1 << picks[p]);
            seen_b |= 8'(1 << picks[p + 5]);
        end
        check("u1_first5", seen_a, 8'h1F);
        check("u1_second5", seen_b, 8'h1F);
        check("u1_no_repeat", picks[5] != picks[4], 1);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_start(2);
        check("u2_sel0", sel2, 0);
        n = 0;
        while (act2 && n < 200) begin
            tick();
            n++;
        end
        check("u2_run_len", n, 100);
        check("u2_to_pulse", to2, 1);
        check("u2_to_count", cnt2, 1);
        tick();
        check("u2_to_one", to2, 0);

        wait_start(2);
        check("u2_sel1", sel2, 1);
        tick();
        done2 = 4'b0100;
        tick();
        done2 = '0;
        check("u2_nonsel_done", act2, 1);
        repeat (97) tick();
        done2 = 4'b0010;
        tick();
        done2 = '0;
        check("u2_both_count", cnt2, 2);
        check("u2_both_no_to", to2, 0);
        check("u2_both_off", act2, 0);
        done2 = 4'b0100;

        wait_start(2);
        check("u2_sel2", sel2, 2);
        tick();
        done2 = '0;
        check("u2_stale_c2", act2, 1);
        tick();
        check("u2_stale_c3", act2, 1);
        check("u2_stale_count", cnt2, 2);
        done2 = 4'b0100;
        tick();
        done2 = '0;
        check("u2_late_count", cnt2, 3);
        check("u2_late_no_to", to2, 0);

        wait_start(2);
        check("u2_sel3", sel2, 3);
        tick();
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        check("u2_abort_act", act2, 0);
        check("u2_abort_count", cnt2, 3);
        repeat (3) tick();
        check("u2_idle_act", act2, 0);
        check("u2_idle_sel", sel2, 3);

        start2 = 1'b1;
        abort2 = 1'b1;
        tick();
        start2 = 1'b0;
        abort2 = 1'b0;
        check("u2_sa_act", act2, 0);
        repeat (3) tick();
        check("u2_sa_idle", act2, 0);
        check("u2_sa_count", cnt2, 3);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int j = 0; j < 2; j++) begin
            wait_start(2);
            check("u2_restart_sel", sel2, j);
            tick();
            done2 = 4'(1 << j);
            tick();
            done2 = '0;
        end
        check("u2_gap_count", cnt2, 2);
        check("u2_gap_data", dout2, slot_v[1]);
        rst = 1'b0;
        #1;
        check("u2_arst_count", cnt2, 0);
        check("u2_arst_sel", sel2, 0);
        check("u2_arst_data", dout2, 0);
        check("u2_arst_act", act2, 0);
        check("u2_arst_start", st2, 0);
        check("u2_arst_victory", vic2, 0);
        check("u2_arst_timeout", to2, 0);
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_sequencer.md
Name: obstacle_sequencer

Overview:
- Parametrised successor to the fixed 8-slot obstacle control/counter/mux cluster.
- Sequences NUM_OBS obstacle generators in sequential or pseudo-random non-repeating order, and issues a start pulse to the selected generator.
- Enforces a per-obstacle timeout, counts completed obstacles and declares victory at a programmable count.
- Provides a registered, zero-gated mux of the selected obstacle's {x, y, rgb} bus; sits between the obstacle generators and the collision/draw stage.

Parameters:
- NUM_OBS, 8, number of obstacle slots (2..16).
- SEL_W, 4, width of the select code; must satisfy 2^SEL_W >= NUM_OBS.
- DATA_W, 36, per-slot data width ({x[11:0], y[11:0], rgb[11:0]}).
- MODE, 1, 0 = sequential 0..NUM_OBS-1 wrapping, 1 = LFSR random without repetition.
- GAP_CYCLES, 1024, idle cycles between obstacles (0 allowed).
- TIMEOUT_CYCLES, 0, maximum RUN cycles per obstacle; 0 disables the timeout.
- WIN_COUNT, 16, completions required for victory; 0 = endless.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  play_selected; begins or restarts a game.
- abort  in  1  game over / menu entry.
- done_in  in  NUM_OBS  per-slot done flags from the generators.
- obs_data_in  in  NUM_OBS*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W].
- obs_select  out  SEL_W  current obstacle code.
- obs_start  out  1  one-cycle start pulse to the selected generator.
- obs_active  out  1  high in RUN.
- obs_data_out  out  DATA_W  registered selected slot data.
- obstacles_counted  out  16  completions since start.
- victory  out  1  held high in WIN.
- timeout  out  1  one-cycle pulse when a timeout ends an obstacle.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; used mask 0; LFSR=LFSR_SEED; all counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle outside reset.
- Priority: abort > start > internal transitions.
  - abort in any state -> IDLE next cycle; mask cleared; obstacles_counted held; victory cleared.
  - start in IDLE or WIN -> LOAD; obstacles_counted=0; mask=0. start in LOAD/RUN/GAP is ignored.
- States:
  - IDLE: outputs inactive; waits for start.
  - LOAD:
    - MODE 0: next = (prev+1) mod NUM_OBS; first pick after start is 0. Takes 1 cycle.
    - MODE 1: candidate = LFSR[SEL_W-1:0]. If candidate >= NUM_OBS or is used, step candidate +1 mod NUM_OBS each cycle until unused. Worst case NUM_OBS+1 cycles.
    - When the mask is full at LOAD entry, reset mask to only the previous pick's bit, so there is no immediate repeat when NUM_OBS>1.
    - On exit: set the mask bit, latch obs_select, pulse obs_start on the cycle RUN is entered.
  - RUN:
    - obs_active=1; the run counter increments each cycle.
    - done_in[obs_select] is honoured only from the 2nd RUN cycle on (a stale done is ignored). done_in of non-selected slots is ignored.
    - Done or timeout (run counter == TIMEOUT_CYCLES-1, TIMEOUT_CYCLES != 0) -> completion.
    - Done and timeout in the same cycle count as a done: no timeout pulse.
  - Completion:
    - obstacles_counted increments, saturating at 16'hFFFF.
    - If the new count == WIN_COUNT and WIN_COUNT != 0 -> WIN; otherwise -> GAP.
  - GAP: counts GAP_CYCLES, then -> LOAD. GAP_CYCLES=0 goes straight to LOAD.
  - WIN: victory=1; obs_active=0; waits for start or abort.
- obs_data_out:
  - Registered, latency 1: next = RUN ? slot[obs_select] : 0.
  - Out-of-range select yields 0.
- obs_select holds its last value in GAP/WIN/IDLE; it is 0 after reset.

Test Plan:
- MODE=0, NUM_OBS=4, GAP=2, WIN=6: start, assert done_in[sel] 5 cycles into each RUN.
  -> obs_select 0,1,2,3,0,1; obs_start one pulse per RUN; obstacles_counted=6; victory=1; obs_active=0.
- MODE=1, NUM_OBS=5, WIN=10, seed default: record selections.
  -> each of 0..4 appears exactly once in picks 1-5 and again in picks 6-10; pick 6 != pick 5.
- TIMEOUT_CYCLES=100, no done driven.
  -> RUN lasts exactly 100 cycles; timeout pulse 1 cycle; count +1.
- Done and timeout in the same cycle -> count +1, timeout stays 0.
- done_in[sel] already high on the first RUN cycle, dropped on the 2nd -> no completion; completion only on a later assertion.
- Non-selected done_in[2]=1 while sel=1 -> ignored.
- obs_data_in slot 3 = 36'h123_456_F00 while sel=3 in RUN -> obs_data_out = 36'h123_456_F00 one cycle later, and 0 one cycle after leaving RUN.
- abort during RUN with count=3 -> IDLE next cycle; count stays 3.
- start and abort asserted together -> IDLE.
- rst pulsed low mid-GAP -> all outputs 0 immediately.
